// File: rtl/trng_entropy_pool.sv
// Health-tested entropy pool: RCT/APT on raw TRNG words, rotate-XOR conditioning, FWFT FIFO.
// Optional adaptive proportion test compiled in with `define TRNG_APT_EN.
module trng_entropy_pool #(
  parameter int DATA_W        = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARTUP_WORDS = 8,
  parameter int RCT_CUTOFF    = 3,
  parameter int APT_WINDOW    = 16,
  parameter int APT_LO        = 200,
  parameter int APT_HI        = 312
) (
  input  logic                            wb_clk_i,
  input  logic                            rst_ni,
  input  logic                            trng_valid_i,
  input  logic [DATA_W-1:0]               trng_data_i,
  output logic                            trng_ready_o,
  input  logic                            rd_en_i,
  output logic [DATA_W-1:0]               rd_data_o,
  output logic                            rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            startup_done_o,
  output logic                            health_fail_o,
  input  logic                            clear_fail_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REP_W = $clog2(RCT_CUTOFF + 1);
  localparam int SU_W  = $clog2(STARTUP_WORDS + 1);

  typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_FAIL} state_e;

  state_e              state_q, state_d;
  logic [SU_W-1:0]     su_cnt_q, su_cnt_d;
  logic                clear_tests;

  logic [DATA_W-1:0]   prev_raw_q;
  logic                prev_vld_q;
  logic [REP_W-1:0]    rep_cnt_q;
  logic [REP_W-1:0]    rep_next;
  logic                rct_fail;
  logic                apt_fail;

  logic [DATA_W-1:0]   cond_q;
  logic [DATA_W-1:0]   cond;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [LVL_W-1:0]    level_q;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic full, accept, testing, health_trip, push, pop, flush;

  assign full         = (level_q == LVL_W'(FIFO_DEPTH));
  assign trng_ready_o = (state_q == ST_RUN) ? !full : 1'b1;
  assign accept       = trng_valid_i && trng_ready_o;
  assign testing      = accept && (state_q != ST_FAIL);

  assign rep_next = (prev_vld_q && (trng_data_i == prev_raw_q)) ? rep_cnt_q + REP_W'(1)
                                                                 : REP_W'(1);
  assign rct_fail = (rep_next >= REP_W'(RCT_CUTOFF));

  assign cond = trng_data_i ^ {cond_q[DATA_W-2:0], cond_q[DATA_W-1]};

  assign health_trip = testing && (rct_fail || apt_fail);
  assign push        = testing && (state_q == ST_RUN) && !health_trip;
  assign rd_valid_o  = (level_q != '0);
  assign pop         = rd_en_i && rd_valid_o && (state_q != ST_FAIL);
  // Entering FAIL wipes the FIFO in the same edge that latches the fault.
  assign flush       = health_trip || (state_q == ST_FAIL);

`ifdef TRNG_APT_EN
  localparam int PC_W      = $clog2(DATA_W + 1);
  localparam int APT_SUM_W = $clog2(DATA_W * APT_WINDOW + 1);
  localparam int APT_CNT_W = $clog2(APT_WINDOW + 1);

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  logic [APT_SUM_W-1:0] apt_sum_q, apt_sum_next;
  logic [APT_CNT_W-1:0] apt_cnt_q;
  logic                 apt_last;

  assign apt_sum_next = apt_sum_q + APT_SUM_W'(popcount(trng_data_i));
  assign apt_last     = (apt_cnt_q == APT_CNT_W'(APT_WINDOW - 1));
  assign apt_fail     = apt_last && ((apt_sum_next < APT_SUM_W'(APT_LO)) ||
                                     (apt_sum_next > APT_SUM_W'(APT_HI)));

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      apt_sum_q <= '0;
      apt_cnt_q <= '0;
    end else if (clear_tests) begin
      apt_sum_q <= '0;
      apt_cnt_q <= '0;
    end else if (testing) begin
      if (apt_last) begin
        apt_sum_q <= '0;
        apt_cnt_q <= '0;
      end else begin
        apt_sum_q <= apt_sum_next;
        apt_cnt_q <= apt_cnt_q + APT_CNT_W'(1);
      end
    end
  end
`else
  logic apt_cfg_unused;
  assign apt_cfg_unused = ((APT_WINDOW + APT_LO + APT_HI) != 0);
  assign apt_fail       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    su_cnt_d    = su_cnt_q;
    clear_tests = 1'b0;
    case (state_q)
      ST_STARTUP: begin
        if (health_trip) begin
          state_d = ST_FAIL;
        end else if (testing) begin
          if (su_cnt_q == SU_W'(STARTUP_WORDS - 1)) begin
            state_d  = ST_RUN;
            su_cnt_d = '0;
          end else begin
            su_cnt_d = su_cnt_q + SU_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (health_trip) state_d = ST_FAIL;
      end
      ST_FAIL: begin
        if (clear_fail_i) begin
          state_d     = ST_STARTUP;
          su_cnt_d    = '0;
          clear_tests = 1'b1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_STARTUP;
      su_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      su_cnt_q <= su_cnt_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_raw_q <= '0;
      prev_vld_q <= 1'b0;
      rep_cnt_q  <= '0;
      cond_q     <= '0;
    end else if (clear_tests) begin
      prev_vld_q <= 1'b0;
      rep_cnt_q  <= '0;
      cond_q     <= '0;
    end else begin
      if (testing) begin
        prev_raw_q <= trng_data_i;
        prev_vld_q <= 1'b1;
        rep_cnt_q  <= rep_next;
      end
      if (push) cond_q <= cond;
    end
  end

  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

  // Head register: next entry on pop, or the incoming word when it lands in an empty slot.
  always_comb begin
    rd_data_d = rd_data_q;
    if (!flush) begin
      if (pop && (level_q > LVL_W'(1)))
        rd_data_d = mem_q[rd_ptr_inc];
      else if (push && ((level_q == '0) || pop))
        rd_data_d = cond;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= cond;
          wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_inc;
        case ({push, pop})
          2'b10:   level_q <= level_q + LVL_W'(1);
          2'b01:   level_q <= level_q - LVL_W'(1);
          default: level_q <= level_q;
        endcase
      end
    end
  end

  assign rd_data_o      = rd_data_q;
  assign fifo_level_o   = level_q;
  assign startup_done_o = (state_q == ST_RUN);
  assign health_fail_o  = (state_q == ST_FAIL);

endmodule

// File: tb/tb_trng_entropy_pool.sv
// Directed bench for trng_entropy_pool: startup, conditioning, RCT fault/clear, FIFO, APT, async reset.
module tb_trng_entropy_pool;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        trng_valid_i;
  logic [31:0] trng_data_i;
  logic        trng_ready_o;
  logic        rd_en_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic [2:0]  fifo_level_o;
  logic        startup_done_o;
  logic        health_fail_o;
  logic        clear_fail_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trng_entropy_pool dut (
    .wb_clk_i       (clk),
    .rst_ni         (rst_ni),
    .trng_valid_i   (trng_valid_i),
    .trng_data_i    (trng_data_i),
    .trng_ready_o   (trng_ready_o),
    .rd_en_i        (rd_en_i),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .fifo_level_o   (fifo_level_o),
    .startup_done_o (startup_done_o),
    .health_fail_o  (health_fail_o),
    .clear_fail_i   (clear_fail_i)
  );

  task automatic do_reset();
    rst_ni = 1'b0; trng_valid_i = 1'b0; trng_data_i = '0; rd_en_i = 1'b0; clear_fail_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    trng_valid_i = 1'b1; trng_data_i = d;
    while (!trng_ready_o && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!trng_ready_o) begin
      errors++; $display("FAIL accept_timeout: got ready=%b required ready=1", trng_ready_o);
    end
    @(posedge clk); #1;
    trng_valid_i = 1'b0;
  endtask

  task automatic pop_one();
    rd_en_i = 1'b1;
    @(posedge clk); #1;
    rd_en_i = 1'b0;
  endtask

  task automatic startup_alt();
    for (int i = 0; i < 8; i++) send_word(i[0] ? 32'h5A5A5A5A : 32'hA5A5A5A5);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (trng_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", trng_ready_o); end
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b required 0", rd_valid_o); end
    checks++; if (rd_data_o !== 32'h0) begin errors++; $display("FAIL rst_rd_data: got %h required 0", rd_data_o); end
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d required 0", fifo_level_o); end
    checks++; if (startup_done_o !== 1'b0 || health_fail_o !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got done=%b fail=%b required 0/0", startup_done_o, health_fail_o); end
  endtask

  task automatic test_startup();
    for (int i = 0; i < 7; i++) send_word(i[0] ? 32'h5A5A5A5A : 32'hA5A5A5A5);
    checks++; if (startup_done_o !== 1'b0) begin errors++; $display("FAIL done_after_7: got %b required 0", startup_done_o); end
    send_word(32'h5A5A5A5A);
    checks++; if (startup_done_o !== 1'b1) begin errors++; $display("FAIL done_after_8: got %b required 1", startup_done_o); end
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL startup_no_push: got %b required 0", rd_valid_o); end
    send_word(32'hA5A5A5A5);
    checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL first_push: got valid=%b data=%h required 1/a5a5a5a5", rd_valid_o, rd_data_o); end
  endtask

  task automatic test_conditioning();
    pop_one();
    checks++; if (rd_valid_o !== 1'b0 || rd_data_o !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL hold_when_empty: got valid=%b data=%h required 0/a5a5a5a5", rd_valid_o, rd_data_o); end
    send_word(32'h00000001);
    checks++; if (rd_data_o !== 32'h4B4B4B4A) begin errors++; $display("FAIL cond_rotxor: got %h required 4b4b4b4a", rd_data_o); end
    pop_one();
  endtask

  task automatic test_rct();
    send_word(32'h12345678);
    send_word(32'h12345678);
    checks++; if (fifo_level_o !== 3'd2 || health_fail_o !== 1'b0) begin
      errors++; $display("FAIL rct_two_ok: got level=%0d fail=%b required 2/0", fifo_level_o, health_fail_o); end
    send_word(32'h12345678);
    checks++; if (health_fail_o !== 1'b1) begin errors++; $display("FAIL rct_trip: got %b required 1", health_fail_o); end
    checks++; if (fifo_level_o !== 3'd0 || rd_valid_o !== 1'b0 || startup_done_o !== 1'b0) begin
      errors++; $display("FAIL rct_flush: got level=%0d valid=%b done=%b required 0/0/0", fifo_level_o, rd_valid_o, startup_done_o); end
    checks++; if (trng_ready_o !== 1'b1) begin errors++; $display("FAIL fail_ready: got %b required 1", trng_ready_o); end
    send_word(32'h00000077);
    checks++; if (fifo_level_o !== 3'd0 || health_fail_o !== 1'b1) begin
      errors++; $display("FAIL fail_drain: got level=%0d fail=%b required 0/1", fifo_level_o, health_fail_o); end
    clear_fail_i = 1'b1;
    @(posedge clk); #1;
    clear_fail_i = 1'b0;
    checks++; if (health_fail_o !== 1'b0 || startup_done_o !== 1'b0) begin
      errors++; $display("FAIL clear: got fail=%b done=%b required 0/0", health_fail_o, startup_done_o); end
    startup_alt();
    checks++; if (startup_done_o !== 1'b1) begin errors++; $display("FAIL restart_done: got %b required 1", startup_done_o); end
    send_word(32'h00000003);
    checks++; if (rd_data_o !== 32'h00000003) begin errors++; $display("FAIL cond_cleared: got %h required 00000003", rd_data_o); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    startup_alt();
    send_word(32'h00000001); send_word(32'h00000010);
    send_word(32'h00000100); send_word(32'h00001000);
    checks++; if (fifo_level_o !== 3'd4 || trng_ready_o !== 1'b0) begin
      errors++; $display("FAIL full: got level=%0d ready=%b required 4/0", fifo_level_o, trng_ready_o); end
    checks++; if (rd_data_o !== 32'h00000001) begin errors++; $display("FAIL head0: got %h required 00000001", rd_data_o); end
    pop_one();
    checks++; if (rd_data_o !== 32'h00000012 || fifo_level_o !== 3'd3) begin
      errors++; $display("FAIL pop1: got data=%h level=%0d required 00000012/3", rd_data_o, fifo_level_o); end
    pop_one();
    checks++; if (rd_data_o !== 32'h00000124 || fifo_level_o !== 3'd2) begin
      errors++; $display("FAIL pop2: got data=%h level=%0d required 00000124/2", rd_data_o, fifo_level_o); end
    trng_valid_i = 1'b1; trng_data_i = 32'h00010000; rd_en_i = 1'b1;
    @(posedge clk); #1;
    trng_valid_i = 1'b0; rd_en_i = 1'b0;
    checks++; if (rd_data_o !== 32'h00001248 || fifo_level_o !== 3'd2) begin
      errors++; $display("FAIL push_pop: got data=%h level=%0d required 00001248/2", rd_data_o, fifo_level_o); end
    pop_one();
    checks++; if (rd_data_o !== 32'h00012490 || fifo_level_o !== 3'd1) begin
      errors++; $display("FAIL pop3: got data=%h level=%0d required 00012490/1", rd_data_o, fifo_level_o); end
    pop_one();
    checks++; if (rd_valid_o !== 1'b0 || rd_data_o !== 32'h00012490) begin
      errors++; $display("FAIL pop_empty: got valid=%b data=%h required 0/00012490", rd_valid_o, rd_data_o); end
    pop_one();
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("FAIL pop_ignored: got %0d required 0", fifo_level_o); end
  endtask

  task automatic test_apt();
    logic exp_fail;
`ifdef TRNG_APT_EN
    exp_fail = 1'b1;
`else
    exp_fail = 1'b0;
`endif
    do_reset();
    rd_en_i = 1'b1;
    for (int i = 0; i < 15; i++) send_word(i[0] ? 32'h000000F0 : 32'h0000000F);
    checks++; if (health_fail_o !== 1'b0) begin errors++; $display("FAIL apt_lo_early: got %b required 0", health_fail_o); end
    send_word(32'h000000F0);
    checks++; if (health_fail_o !== exp_fail) begin errors++; $display("FAIL apt_lo_window: got %b required %b", health_fail_o, exp_fail); end
    do_reset();
    rd_en_i = 1'b1;
    for (int i = 0; i < 16; i++) send_word(i[0] ? 32'hFFFF0000 : 32'h0000FFFF);
    rd_en_i = 1'b0;
    checks++; if (health_fail_o !== 1'b0 || startup_done_o !== 1'b1) begin
      errors++; $display("FAIL apt_mid_window: got fail=%b done=%b required 0/1", health_fail_o, startup_done_o); end
  endtask

  task automatic test_async_reset();
    send_word(32'h00C0FFEE);
    checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b required 1", rd_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (rd_valid_o !== 1'b0 || fifo_level_o !== 3'd0 || rd_data_o !== 32'h0) begin
      errors++; $display("FAIL async_fifo: got valid=%b level=%0d data=%h required 0/0/0", rd_valid_o, fifo_level_o, rd_data_o); end
    checks++; if (startup_done_o !== 1'b0 || health_fail_o !== 1'b0 || trng_ready_o !== 1'b1) begin
      errors++; $display("FAIL async_ctrl: got done=%b fail=%b ready=%b required 0/0/1", startup_done_o, health_fail_o, trng_ready_o); end
    @(posedge clk); #1 rst_ni = 1'b1;
    @(posedge clk); #1;
    startup_alt();
    checks++; if (startup_done_o !== 1'b1) begin errors++; $display("FAIL post_reset_startup: got %b required 1", startup_done_o); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_conditioning();
    test_rct();
    test_fifo_full();
    test_apt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
